ce_rs_tx_sched: RTL
===================

Name: ce_rs_tx_sched

Overview:
Scheduler that shares one RS-tx ZC sequence ROM pair (real/imag, 11-bit address, 1-clk registered read) between NREQ channel-estimation requesters.
- Arbitrates between requesters, then generates a burst of ROM addresses from a per-requester base (cyclic start offset) for a per-requester length.
- Delivers the ROM samples with valid/first/last framing and the granted requester ID.
- Sits between the CE LS engines and the RS-tx ROMs.

Parameters:
- NREQ, 2, number of requesters (2..4).
- wDataOut, 18, ROM sample width.
- ROM_DEPTH, 1200, ROM words; address wraps modulo this value.
- GAP_CYC, 2, idle cycles forced between bursts (>=1).

Ports:
- clk  in  1  clock.
- rst_n_sync  in  1  reset, asynchronous assert, active-low.
- req  in  NREQ  per-requester burst request, level; held until its ack.
- req_base  in  NREQ*11  per-requester start address (< ROM_DEPTH), sampled at grant.
- req_len  in  NREQ*11  per-requester burst length (1..ROM_DEPTH), sampled at grant; 0 is treated as 1.
- ack  out  NREQ  one-hot, 1-clk pulse at grant.
- rom_addr  out  11  ROM address, shared by both ROMs.
- rom_q_real  in  wDataOut  ROM real output, 1 clk after rom_addr.
- rom_q_imag  in  wDataOut  ROM imag output.
- source_valid  out  1  sample valid.
- source_sop  out  1  first sample of burst.
- source_eop  out  1  last sample of burst.
- source_id  out  2  requester owning the current sample.
- source_real  out  wDataOut  registered ROM real.
- source_imag  out  wDataOut  registered ROM imag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-low): all outputs 0, rom_addr=0, state IDLE, round-robin pointer=0. Reset asserted mid-burst truncates the burst immediately; no eop is emitted.
- State machine:
  - IDLE: if any req, pick a winner, pulse ack[winner], latch base/len/id, go to RUN. Otherwise stay.
  - RUN: one address per clk. First rom_addr=base; increment by 1; after ROM_DEPTH-1 wrap to 0. Count len addresses, then go to GAP.
  - GAP: count GAP_CYC cycles, then return to IDLE. Arbitration happens only in IDLE.
- Arbitration: round-robin starting after the last winner; pointer updated at each grant. Simultaneous requests are resolved by the pointer.
- Address arithmetic: next = (addr==ROM_DEPTH-1) ? 0 : addr+1. base >= ROM_DEPTH is reduced by subtracting ROM_DEPTH once at latch.
- Latency: source_* lags its rom_addr by exactly 2 clks (1 ROM register, 1 output register).
  - source_valid high for exactly len consecutive cycles.
  - sop on the first of these cycles, eop on the last; both on the same cycle when len=1.
  - source_id is constant during a burst.
- Outside a burst, rom_addr holds its last value; source_real/imag hold their last value while source_valid=0.
- A requester that deasserts req after ack does not affect an ongoing burst. A req held after its own ack is re-arbitrated as a new request in the next IDLE.
- Minimum spacing between bursts: GAP_CYC + 1 idle clks on source_valid (GAP cycles plus the IDLE grant cycle).

Optional Feature:
RS_SCHED_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; round-robin pointer logic is removed.
- Undefined: round-robin as above.
- Latency and framing are identical in both builds.

Test Plan:
- Single request: req=01, base=0, len=12, GAP_CYC=2.
  - ack=01 one clk; rom_addr 0..11.
  - source_valid 12 clks starting 2 clks after addr 0; sop on first, eop on 12th.
  - source_real equals ROM words 0..11.
- Wrap: base=1195, len=8, ROM_DEPTH=1200 -> rom_addr 1195..1199,0,1,2; eop on the 8th sample.
- Contention: req=11 held continuously, len=4 each.
  - Round-robin build: bursts alternate id 0,1,0,1 with 3 idle clks between valid runs.
  - With RS_SCHED_FIXED_PRIO_EN: every burst has id 0.
- len=1 and len=0: exactly one valid sample with sop=eop=1 in the same cycle.
- Reset mid-burst: assert rst_n_sync=0 at sample 5 of len=20.
  - All outputs 0 immediately (asynchronous).
  - After release: state IDLE, no eop; a new req is served starting at its base.
- Late request change: alter req_len/req_base and drop req one clk after ack -> burst uses the values latched at grant; no second ack.

Source files
------------

// File: rtl/ce_rs_tx_sched.sv
// ce_rs_tx_sched: shares one RS-tx ZC ROM pair (real/imag, 1-clk registered
// read) between NREQ channel-estimation requesters. A requester is granted
// in IDLE, then a burst of len consecutive ROM addresses starting at its base
// (wrapping modulo ROM_DEPTH) is issued. A GAP of GAP_CYC idle cycles follows
// each burst. Samples come out 2 clks after their address with sop/eop/id
// framing.
// Build option: define RS_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// index wins). Leave it undefined for round-robin arbitration.
module ce_rs_tx_sched #(
    parameter int NREQ      = 2,
    parameter int wDataOut  = 18,
    parameter int ROM_DEPTH = 1200,
    parameter int GAP_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n_sync,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*11-1:0]   req_base,
    input  logic [NREQ*11-1:0]   req_len,
    output logic [NREQ-1:0]      ack,
    output logic [10:0]          rom_addr,
    input  logic [wDataOut-1:0]  rom_q_real,
    input  logic [wDataOut-1:0]  rom_q_imag,
    output logic                 source_valid,
    output logic                 source_sop,
    output logic                 source_eop,
    output logic [1:0]           source_id,
    output logic [wDataOut-1:0]  source_real,
    output logic [wDataOut-1:0]  source_imag,
    output logic                 busy
);

    localparam int          GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [10:0] DEPTH_M1 = 11'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    state_t         state_q, state_d;
    logic [NREQ-1:0] ack_q;
    logic [10:0]    rom_addr_q;
    logic [10:0]    cnt_q;        // addresses remaining after the current one
    logic [GW-1:0]  gap_cnt_q;
    logic [1:0]     id_q;
    logic           first_q;      // current RUN address is the burst's first

    // Stage 1: framing aligned with the ROM output (1 clk after the address)
    logic           s1_valid_q, s1_sop_q, s1_eop_q;
    logic [1:0]     s1_id_q;

    // Stage 2: registered outputs
    logic           out_valid_q, out_sop_q, out_eop_q;
    logic [1:0]     out_id_q;
    logic [wDataOut-1:0] out_real_q, out_imag_q;

    logic           any_req;
    logic [1:0]     win_id;
    logic [NREQ-1:0] grant_oh;
    logic [10:0]    sel_base, sel_len, base_eff, len_m1, addr_inc;

    assign any_req = |req;

    // Arbitration: choose the winning requester index
`ifdef RS_SCHED_FIXED_PRIO_EN
    always_comb begin
        win_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = 2'(i);
        end
    end
`else
    logic [1:0] rr_ptr_q;     // highest-priority index for the next grant

    always_comb begin : arb_rr
        logic found;
        int   idx;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    found  = 1'b1;
                    win_id = 2'(i);
                end
            end
        end
    end

    // Round-robin pointer moves to one past the winner at each grant
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rr_ptr_q <= '0;
        end else if (state_q == ST_IDLE && any_req) begin
            rr_ptr_q <= (int'(win_id) == NREQ - 1) ? 2'd0 : win_id + 2'd1;
        end
    end
`endif

    // Winner one-hot plus its base/len fields
    always_comb begin
        grant_oh = '0;
        sel_base = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == 2'(i)) begin
                grant_oh[i] = any_req;
                sel_base    = req_base[i*11 +: 11];
                sel_len     = req_len[i*11 +: 11];
            end
        end
    end

    // Base folded once into the ROM range; len of 0 behaves as 1
    assign base_eff = ({1'b0, sel_base} >= 12'(ROM_DEPTH)) ? sel_base - 11'(ROM_DEPTH) : sel_base;
    assign len_m1   = (sel_len == 11'd0) ? 11'd0 : sel_len - 11'd1;
    assign addr_inc = (rom_addr_q == DEPTH_M1) ? 11'd0 : rom_addr_q + 11'd1;

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_req)            state_d = ST_RUN;
            ST_RUN:  if (cnt_q == 11'd0)     state_d = ST_GAP;
            ST_GAP:  if (gap_cnt_q == '0)    state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // FSM state register and burst datapath (grant latch, address, counters)
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            rom_addr_q <= '0;
            cnt_q      <= '0;
            gap_cnt_q  <= '0;
            id_q       <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        ack_q      <= grant_oh;
                        id_q       <= win_id;
                        rom_addr_q <= base_eff;
                        cnt_q      <= len_m1;
                        first_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    first_q <= 1'b0;
                    if (cnt_q != 11'd0) begin
                        rom_addr_q <= addr_inc;
                        cnt_q      <= cnt_q - 11'd1;
                    end else begin
                        gap_cnt_q <= GW'(GAP_CYC - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stage 1 framing: tracks the address cycle by one clk, like the ROM data
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= (state_q == ST_RUN);
            s1_sop_q   <= (state_q == ST_RUN) && first_q;
            s1_eop_q   <= (state_q == ST_RUN) && (cnt_q == 11'd0);
            s1_id_q    <= id_q;
        end
    end

    // Stage 2 output register: data and id captured only on valid samples
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_id_q    <= '0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_sop_q   <= s1_sop_q;
            out_eop_q   <= s1_eop_q;
            if (s1_valid_q) begin
                out_id_q   <= s1_id_q;
                out_real_q <= rom_q_real;
                out_imag_q <= rom_q_imag;
            end
        end
    end

    assign ack          = ack_q;
    assign rom_addr     = rom_addr_q;
    assign source_valid = out_valid_q;
    assign source_sop   = out_sop_q;
    assign source_eop   = out_eop_q;
    assign source_id    = out_id_q;
    assign source_real  = out_real_q;
    assign source_imag  = out_imag_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
